// File: rtl/one_hot_pulse_mon_pkg.sv
`default_nettype none
// ============================================================================
// one_hot_pulse_mon_pkg : shared FSM encoding and default ring-divider settings
// Rev 1.0
// ============================================================================
package one_hot_pulse_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } mon_state_t;

    // Also used by the transmitting divider so both ends agree on the pattern.
    localparam int c_def_n        = 5;
    localparam int c_def_exp_high = 1;

endpackage
`default_nettype wire

// File: rtl/one_hot_pulse_mon_sync_edge_det.sv
`default_nettype none
// ============================================================================
// one_hot_pulse_mon_sync_edge_det : multi-flop synchroniser with rise/fall detect
// Rev 1.0
// ============================================================================
module one_hot_pulse_mon_sync_edge_det
    import one_hot_pulse_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_s_d  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign s    = r_sync[SYNC_STAGES-1];
    assign rise = s & ~r_s_d;
    assign fall = ~s & r_s_d;

endmodule
`default_nettype wire

// File: rtl/one_hot_pulse_mon.sv
`default_nettype none
// ============================================================================
// one_hot_pulse_mon : period/high-time checker and lock detector for a one-hot
// divider pulse. Optional sticky lock-loss flag: ONE_HOT_MON_STICKY_LOSS_EN.
// Rev 1.0
// ============================================================================
module one_hot_pulse_mon
    import one_hot_pulse_mon_pkg::*;
#(
    parameter int N           = c_def_n,
    parameter int EXP_HIGH    = c_def_exp_high,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 4,
    parameter int CNT_W       = 8,
    parameter int ERR_W       = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             pulse_in,
    input  logic             clear,
    output logic             locked,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_len,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_pulse,
    output logic             lock_lost
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] c_period  = CNT_W'(N);
    localparam logic [CNT_W-1:0] c_high    = CNT_W'(EXP_HIGH);
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(2 * N);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
    localparam logic [RUN_W-1:0] c_run_max = RUN_W'(LOCK_CNT - 1);

    logic             w_s;
    logic             w_rise;
    logic             w_fall;
    mon_state_t       r_state;
    mon_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_hi;
    logic [CNT_W-1:0] r_hi_q;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] w_run_nxt;
    logic             w_good;
    logic             w_timeout;
    logic             w_err;
    logic             w_lock_nxt;

    one_hot_pulse_mon_sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (pulse_in),
        .s     (w_s),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    // Timeout is only reachable on a non-rise cycle because rise reloads cyc.
    always_comb begin
        w_good      = (r_cyc == c_period) && (r_hi_q == c_high);
        w_timeout   = (r_cyc >= c_timeout);
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_err       = 1'b0;
        w_lock_nxt  = locked;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_MEASURE;
                    w_run_nxt   = '0;
                end
            end
            ST_MEASURE: begin
                if (w_rise) begin
                    if (w_good) begin
                        if (r_run == c_run_max) begin
                            w_state_nxt = ST_LOCKED;
                            w_run_nxt   = '0;
                            w_lock_nxt  = 1'b1;
                        end else begin
                            w_run_nxt = r_run + RUN_W'(1);
                        end
                    end else begin
                        w_run_nxt = '0;
                        w_err     = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_run_nxt   = '0;
                    w_err       = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_rise) begin
                    if (!w_good) begin
                        w_state_nxt = ST_MEASURE;
                        w_run_nxt   = '0;
                        w_lock_nxt  = 1'b0;
                        w_err       = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_run_nxt   = '0;
                    w_lock_nxt  = 1'b0;
                    w_err       = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_run_nxt   = '0;
                w_lock_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= ST_IDLE;
            r_run     <= '0;
            r_cyc     <= '0;
            r_hi      <= '0;
            r_hi_q    <= '0;
            locked    <= 1'b0;
            period    <= '0;
            high_len  <= '0;
            err_cnt   <= '0;
            err_pulse <= 1'b0;
        end else if (clear) begin
            r_state   <= ST_IDLE;
            r_run     <= '0;
            r_cyc     <= '0;
            r_hi      <= '0;
            r_hi_q    <= '0;
            locked    <= 1'b0;
            period    <= '0;
            high_len  <= '0;
            err_cnt   <= '0;
            err_pulse <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_run     <= w_run_nxt;
            locked    <= w_lock_nxt;
            err_pulse <= w_err;
            if (w_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
            if (w_rise) begin
                r_cyc <= c_one;
            end else if (r_cyc != '1) begin
                r_cyc <= r_cyc + c_one;
            end
            if (w_rise) begin
                r_hi <= c_one;
            end else if (w_s && (r_hi != '1)) begin
                r_hi <= r_hi + c_one;
            end
            if (w_fall) begin
                r_hi_q <= r_hi;
            end
            if (w_rise && (r_state != ST_IDLE)) begin
                period   <= r_cyc;
                high_len <= r_hi_q;
            end
        end
    end

`ifdef ONE_HOT_MON_STICKY_LOSS_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lock_lost <= 1'b0;
        end else if (clear) begin
            lock_lost <= 1'b0;
        end else if ((r_state == ST_LOCKED) && (w_state_nxt != ST_LOCKED)) begin
            lock_lost <= 1'b1;
        end
    end
`else
    assign lock_lost = 1'b0;
`endif

endmodule
`default_nettype wire
